// File: rtl/fir_sse_pkg.sv
// Shared types and helpers for the FIR + SSE monitor.
package fir_sse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Working width of the saturating adder; wide enough for a squared error.
  localparam int SAT_W = 128;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Full-precision width of the filter output.
  function automatic int calc_out_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Unsigned a+b clipped to the all-ones value of a w-bit register.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int w);
    logic [SAT_W:0] total;
    logic [SAT_W:0] lim;
    sat_res_t       r;
    total = {1'b0, a} + {1'b0, b};
    lim   = (w >= SAT_W) ? {1'b0, {SAT_W{1'b1}}}
                         : (((SAT_W+1)'(1)) << w) - (SAT_W+1)'(1);
    r.sat = total > lim;
    r.val = r.sat ? lim[SAT_W-1:0] : total[SAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; extra pointer bit distinguishes full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the buffer in one edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_sse_monitor.sv
// Direct-form FIR filter with an on-line SSE / mismatch check against a buffered golden stream.
module fir_sse_monitor
  import fir_sse_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int COEF_W     = 16,
  parameter  int TAPS       = 8,
  parameter  int GOLD_DEPTH = 16,
  parameter  int ACC_W      = 48,
  parameter  int CNT_W      = 16,
  localparam int OUT_W      = calc_out_w(DATA_W, COEF_W, TAPS),
  localparam int AW         = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     gold_valid,
  input  logic [OUT_W-1:0]         gold_data,
  output logic                     gold_ready,
  input  logic [OUT_W:0]           err_thresh,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_filt,
  output logic [OUT_W:0]           out_err,
  output logic [ACC_W-1:0]         out_sse,
  output logic [CNT_W-1:0]         mismatch,
  output logic                     sse_sat,
  output logic                     gold_extra,
  output logic                     ready
);

  localparam int SQ_W = 2 * (OUT_W + 1);

  state_t                     state;
  logic signed [COEF_W-1:0]   coefs [TAPS];
  logic signed [DATA_W-1:0]   taps  [TAPS];
  logic                       tap_new;
  logic signed [OUT_W-1:0]    res;
  logic                       res_valid;
  logic signed [OUT_W-1:0]    mac;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [OUT_W-1:0]           gold_head;

  logic                       idle_like;
  logic                       start_go;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic                       load;
  logic signed [OUT_W:0]      err;
  logic [OUT_W:0]             abs_err;
  logic [SQ_W-1:0]            sq;
  sat_res_t                   sse_next;
  sat_res_t                   cnt_next;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign start_go   = start && idle_like;
  assign in_ready   = (state == RUN) && !(res_valid && fifo_empty);
  assign accept     = in_valid && in_ready;
  assign gold_ready = !rst && !fifo_full;
  assign push       = gold_valid && !fifo_full && ((state == RUN) || (state == DRAIN));
  assign pop        = res_valid && !fifo_empty;
  // A freshly shifted delay line may only produce a result once the result slot is free.
  assign load       = tap_new && (!res_valid || pop);

  assign err      = {res[OUT_W-1], res} - {gold_head[OUT_W-1], gold_head};
  assign abs_err  = err[OUT_W] ? -err : err;
  assign sq       = err * err;
  assign sse_next = sat_add(SAT_W'(out_sse), SAT_W'(sq), ACC_W);
  assign cnt_next = sat_add(SAT_W'(mismatch), SAT_W'(1), CNT_W);

  // Multiply-accumulate over all taps at full output precision.
  always_comb begin
    // NOTE: assigning a default first means no path leaves mac unassigned, so no latch.
    mac = '0;
    for (int i = 0; i < TAPS; i++) begin
      // NOTE: blocking '=' here so each iteration sees the previous partial sum.
      mac = mac + OUT_W'(taps[i]) * OUT_W'(coefs[i]);
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (GOLD_DEPTH)
  ) u_gold_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_go),
    .push      (push),
    .push_data (gold_data),
    .pop       (pop),
    .pop_data  (gold_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Run sequencing with registered ready / gold_extra flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      gold_extra <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            ready      <= 1'b0;
            gold_extra <= 1'b0;
          end
        end
        RUN: begin
          if (stop) state <= DRAIN;
        end
        DRAIN: begin
          if (!tap_new && !res_valid) begin
            state      <= DONE;
            ready      <= 1'b1;
            gold_extra <= !fifo_empty || push;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficients, delay line, result slot and compare/accumulate outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Coefficients are software-visible state, so they return to zero on reset.
      for (int i = 0; i < TAPS; i++) begin
        coefs[i] <= '0;
        taps[i]  <= '0;
      end
      tap_new   <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      out_valid <= 1'b0;
      out_filt  <= '0;
      out_err   <= '0;
      out_sse   <= '0;
      mismatch  <= '0;
      sse_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start_go) begin
        for (int i = 0; i < TAPS; i++) taps[i] <= '0;
        tap_new   <= 1'b0;
        res_valid <= 1'b0;
        out_sse   <= '0;
        mismatch  <= '0;
        sse_sat   <= 1'b0;
      end else begin
        if (coef_we && idle_like && (int'(coef_addr) < TAPS)) coefs[coef_addr] <= coef_data;

        if (load)   tap_new <= 1'b0;
        if (accept) begin
          tap_new <= 1'b1;
          taps[0] <= in_data;
          for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
        end

        if (load) begin
          res       <= mac;
          res_valid <= 1'b1;
        end else if (pop) begin
          res_valid <= 1'b0;
        end

        if (pop) begin
          out_valid <= 1'b1;
          out_filt  <= res;
          out_err   <= err;
          out_sse   <= sse_next.val[ACC_W-1:0];
          if (sse_next.sat) sse_sat <= 1'b1;
          if (abs_err > err_thresh) mismatch <= cnt_next.val[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_sse_monitor.sv
// Directed bench for fir_sse_monitor: queue-based reference model plus literal end-of-run checks.
module tb_fir_sse_monitor;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 35;
  localparam int ACC_W  = 48;
  localparam int CNT_W  = 16;

  typedef longint lq_t[$];

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     stop;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     gold_valid;
  logic [OUT_W-1:0]         gold_data;
  logic [OUT_W:0]           err_thresh;

  logic                     in_ready, gold_ready, out_valid, sse_sat, gold_extra, ready;
  logic [OUT_W-1:0]         out_filt;
  logic [OUT_W:0]           out_err;
  logic [ACC_W-1:0]         out_sse;
  logic [CNT_W-1:0]         mismatch;

  logic                     small_in_ready, small_gold_ready, small_out_valid;
  logic                     small_sse_sat, small_gold_extra, small_ready;
  logic [OUT_W-1:0]         small_out_filt;
  logic [OUT_W:0]           small_out_err;
  logic [7:0]               small_out_sse;
  logic [CNT_W-1:0]         small_mismatch;

  fir_sse_monitor dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .gold_valid(gold_valid), .gold_data(gold_data), .gold_ready(gold_ready),
    .err_thresh(err_thresh), .out_valid(out_valid), .out_filt(out_filt),
    .out_err(out_err), .out_sse(out_sse), .mismatch(mismatch),
    .sse_sat(sse_sat), .gold_extra(gold_extra), .ready(ready)
  );

  fir_sse_monitor #(.ACC_W(8)) dut_small (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(small_in_ready),
    .gold_valid(gold_valid), .gold_data(gold_data), .gold_ready(small_gold_ready),
    .err_thresh(err_thresh), .out_valid(small_out_valid), .out_filt(small_out_filt),
    .out_err(small_out_err), .out_sse(small_out_sse), .mismatch(small_mismatch),
    .sse_sat(small_sse_sat), .gold_extra(small_gold_extra), .ready(small_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  longint       m_coef [TAPS];
  longint       m_hist [$];
  longint       exp_filt [$];
  longint       gold_q [$];
  logic [127:0] m_sse;
  logic [127:0] max_sse;
  int           m_mism;
  bit           m_sat;
  longint       seen_filt [$];
  int           neg1_count;
  int           stall_cycles;

  // Compare-process scratch.
  longint       c_f, c_g, c_e, c_mag;
  logic [OUT_W-1:0] c_f35;
  logic [OUT_W:0]   c_e36;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting on DUT", name);
  endtask

  function automatic lq_t ramp(input int lo, input int hi);
    lq_t q;
    for (int v = lo; v <= hi; v++) q.push_back(longint'(v));
    return q;
  endfunction

  function automatic lq_t rep(input longint val, input int n);
    lq_t q;
    for (int k = 0; k < n; k++) q.push_back(val);
    return q;
  endfunction

  // Filter output for the newest sample of the current run (zeros before the run).
  function automatic longint model_filt();
    longint acc = 0;
    int     n   = m_hist.size();
    for (int k = 0; k < TAPS; k++)
      if (n - 1 - k >= 0) acc += m_coef[k] * m_hist[n-1-k];
    return acc;
  endfunction

  function automatic void model_clear_run();
    m_hist.delete();
    exp_filt.delete();
    gold_q.delete();
    seen_filt.delete();
    m_sse        = '0;
    m_mism       = 0;
    m_sat        = 1'b0;
    neg1_count   = 0;
    stall_cycles = 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_gold_ready"}, gold_ready, 0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_filt"},   out_filt,   0);
    check({tag, "_out_err"},    out_err,    0);
    check({tag, "_out_sse"},    out_sse,    0);
    check({tag, "_mismatch"},   mismatch,   0);
    check({tag, "_sse_sat"},    sse_sat,    0);
    check({tag, "_gold_extra"}, gold_extra, 0);
    check({tag, "_ready"},      ready,      0);
  endtask

  // All driver tasks start and end on a negedge.
  task automatic write_coef(input int addr, input longint val, input bit honoured);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (honoured) m_coef[addr] = val;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear_run();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // in_ready depends only on registered state, so its negedge value decides the next edge.
  task automatic feed_in(input lq_t v);
    for (int k = 0; k < v.size(); k++) begin
      int waited = 0;
      in_valid = 1'b1;
      in_data  = 16'(v[k]);
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        timeout("in_accept");
        break;
      end
      stall_cycles += waited;
      m_hist.push_back(v[k]);
      exp_filt.push_back(model_filt());
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic feed_gold(input lq_t v, input int delay);
    repeat (delay) @(negedge clk);
    for (int k = 0; k < v.size(); k++) begin
      int waited = 0;
      gold_valid = 1'b1;
      gold_data  = 35'(v[k]);
      while (!gold_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!gold_ready) begin
        timeout("gold_accept");
        break;
      end
      gold_q.push_back(v[k]);
      @(negedge clk);
    end
    gold_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) timeout("wait_ready");
  endtask

  // Scoreboard: each out_valid pairs the oldest expected filter value with the oldest gold sample.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_filt.size() == 0 || gold_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got a pulse, required none pending");
      end else begin
        c_f   = exp_filt.pop_front();
        c_g   = gold_q.pop_front();
        c_e   = c_f - c_g;
        c_mag = (c_e < 0) ? -c_e : c_e;
        m_sse = m_sse + 128'(c_mag) * 128'(c_mag);
        if (m_sse > max_sse) begin
          m_sse = max_sse;
          m_sat = 1'b1;
        end
        if (c_mag > longint'(err_thresh) && m_mism < 65535) m_mism++;
        c_f35 = c_f[OUT_W-1:0];
        c_e36 = c_e[OUT_W:0];
        seen_filt.push_back(longint'(out_filt));
        if (out_err == {(OUT_W+1){1'b1}}) neg1_count++;
        check("cmp_filt",     out_filt, c_f35);
        check("cmp_err",      out_err,  c_e36);
        check("cmp_sse",      out_sse,  m_sse);
        check("cmp_mismatch", mismatch, m_mism);
        check("cmp_sse_sat",  sse_sat,  m_sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    lq_t g;
    max_sse    = (128'(1) << ACC_W) - 1;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    gold_valid = 1'b0;
    gold_data  = '0;
    err_thresh = '0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    model_clear_run();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready",   in_ready,   0);
    check("idle_gold_ready", gold_ready, 1);
    check("idle_ready",      ready,      0);

    // Identity filter, matching golden stream.
    write_coef(0, 1, 1'b1);
    do_start();
    fork
      feed_in(ramp(1, 10));
      feed_gold(ramp(1, 10), 0);
    join
    do_stop();
    wait_ready(100);
    check("t1_sse",        out_sse,         0);
    check("t1_mismatch",   mismatch,        0);
    check("t1_ready",      ready,           1);
    check("t1_gold_extra", gold_extra,      0);
    check("t1_in_ready",   in_ready,        0);
    check("t1_drained",    exp_filt.size(), 0);

    // One golden sample off by one, zero threshold.
    do_start();
    g    = ramp(1, 10);
    g[4] = 6;
    fork
      feed_in(ramp(1, 10));
      feed_gold(g, 0);
    join
    do_stop();
    wait_ready(100);
    check("t2_neg1_count", neg1_count, 1);
    check("t2_sse",        out_sse,    1);
    check("t2_mismatch",   mismatch,   1);

    // All-ones coefficients, golden stream late: input must stall.
    for (int k = 0; k < TAPS; k++) write_coef(k, 1, 1'b1);
    do_start();
    fork
      feed_in(rep(1, 8));
      feed_gold(ramp(1, 8), 6);
    join
    do_stop();
    wait_ready(100);
    check("t3_stalled",   stall_cycles > 0, 1);
    check("t3_out_count", seen_filt.size(), 8);
    for (int k = 0; k < 8 && k < seen_filt.size(); k++)
      check("t3_filt_order", seen_filt[k], k + 1);
    check("t3_sse", out_sse, 0);

    // Saturation of the 8-bit accumulator: 20^2 = 400 > 255.
    for (int k = 1; k < TAPS; k++) write_coef(k, 0, 1'b1);
    do_start();
    fork
      feed_in(rep(20, 1));
      feed_gold(rep(0, 1), 0);
    join
    do_stop();
    wait_ready(100);
    check("t4_small_sse",   small_out_sse, 255);
    check("t4_small_sat",   small_sse_sat, 1);
    check("t4_small_ready", small_ready,   1);
    check("t4_main_sse",    out_sse,       400);
    check("t4_main_sat",    sse_sat,       0);

    // Coefficient write during RUN is ignored; two surplus golden samples.
    do_start();
    write_coef(0, 5, 1'b0);
    fork
      feed_in(ramp(1, 10));
      feed_gold(ramp(1, 12), 0);
    join
    do_stop();
    wait_ready(100);
    check("t5_gold_extra", gold_extra, 1);
    check("t5_sse",        out_sse,    0);
    check("t5_mismatch",   mismatch,   0);

    // Reset in the middle of a run.
    do_start();
    fork
      feed_in(ramp(1, 2));
      feed_gold(rep(1, 1), 0);
    join
    repeat (4) @(negedge clk);
    rst = 1'b1;
    model_clear_run();
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    @(negedge clk);
    check_all_zero("midrun_rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",   in_ready,   0);
    check("post_rst_ready",      ready,      0);
    check("post_rst_gold_ready", gold_ready, 1);

    // start and stop together in IDLE: start wins.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    model_clear_run();
    check("t7_running", in_ready, 1);
    do_stop();
    wait_ready(20);
    check("t7_ready",      ready,      1);
    check("t7_sse",        out_sse,    0);
    check("t7_gold_extra", gold_extra, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
